pixel_mixer: RTL and testbench
==============================

Name: pixel_mixer

Overview:
- Downstream consumer of the background and sprite pixel FIFOs in the PPU.
- On each T-cycle it pops one pixel from both FIFOs and discards the first SCX[2:0] pixels of the line.
- It resolves sprite-versus-background priority and maps the winning 2-bit colour index through BGP/OBP0/OBP1 to a 2-bit shade.
- It streams shades with an X coordinate to the LCD writer and signals end of the visible line.

Parameters:
- X_MAX, 160, visible pixels per line; X counter width is $clog2(X_MAX).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- tclk_in  in  1  T-cycle enable, single clk_in pulse per T-cycle
- line_start_in  in  1  pulse: begin mode-3 drawing of a new line
- SCX_in  in  8  background X scroll; only [2:0] is used
- bg_ena_in  in  1  LCDC.0; 0 forces background index to 0
- BGP_in, OBP0_in, OBP1_in  in  8 each  DMG palettes
- bg_pixel_in  in  2  background FIFO head colour index
- bg_valid_in  in  1  background FIFO non-empty
- sprite_pixel_in  in  2  sprite FIFO head colour index
- sprite_valid_in  in  1  sprite FIFO head valid
- sprite_palette_in  in  1  0 selects OBP0, 1 selects OBP1
- sprite_priority_in  in  1  1 means background colours 1-3 cover the sprite
- rd_en_out  out  1  pop strobe to both FIFOs
- X_out  out  $clog2(X_MAX)  screen X of the current shade
- shade_out  out  2  final shade
- shade_valid_out  out  1  shade_out/X_out valid, one clk_in cycle
- line_done_out  out  1  one-cycle pulse after pixel X_MAX-1

Behaviour:
- Reset (async, rst_in=1): state IDLE; all outputs 0; X and discard counters 0.
- States:
  - IDLE: wait for line_start_in.
  - DISCARD: drop SCX[2:0] leading pixels.
  - DRAW: emit visible pixels.
  - DONE: one cycle, pulse line_done_out.
- line_start_in, from any state including mid-line:
  - clears the X counter;
  - loads discard count = SCX_in[2:0] (sampled once, at this event);
  - goes to DISCARD if the count is non-zero, else DRAW;
  - any shade in flight from the previous line is suppressed.
- Pop condition: rd_en_out = tclk_in && bg_valid_in && state in {DISCARD, DRAW}; it is combinational.
  - No pop while the background FIFO is empty; the mixer stalls and X holds.
- DISCARD:
  - each pop decrements the discard count; no shade is emitted;
  - on the pop that takes the count to 0, go to DRAW.
- DRAW, on each pop:
  - Register the resolved shade: shade_valid_out=1 on the next clk_in edge (latency 1 clk_in); X_out = X at pop.
  - bg_idx = bg_ena_in ? bg_pixel_in : 0.
  - Sprite wins iff sprite_valid_in && sprite_pixel_in != 0 && (!sprite_priority_in || bg_idx == 0).
  - shade = palette[2*idx+1 : 2*idx], using OBP0/OBP1 for a winning sprite and BGP otherwise.
  - sprite_valid_in=0 is treated as sprite index 0.
  - X increments. On the pop with X == X_MAX-1, go to DONE; X wraps to 0.
- DONE: line_done_out=1 for exactly one clk_in cycle, then IDLE. Extra pops never occur in IDLE/DONE.
- shade_valid_out and line_done_out are never asserted together for the same pixel. The last shade appears in the same cycle as DONE entry; line_done_out follows one cycle later.

Optional Feature:
- Macro PIXEL_MIXER_SPRITE_MASK_EN.
- Defined: adds input port sprite_mask_in (1 bit). When 1, sprites never win and output equals background-only rendering; used for debug/layer viewing.
- Undefined: the port is absent and behaviour is as above.

Decomposition:
- Package ppu_pkg holds:
  - enum mixer_state_t {IDLE, DISCARD, DRAW, DONE};
  - typedef shade_t (logic [1:0]);
  - typedef color_idx_t (logic [1:0]);
  - function palette_map(palette[7:0], idx) returning shade_t.
- Sub-module pixel_priority_resolver: combinational bg/sprite arbitration plus palette selection, producing a shade. The mixer owns the FSM, counters and output register.

Test Plan:
- Basic line: SCX=0, BGP=0xE4, bg FIFO always valid with index 2, no sprites, line_start pulse -> 160 pops; shade_valid pulses with shade 2 and X 0..159; line_done pulses once one cycle after the X=159 shade.
- Fine scroll: SCX=0x05, bg indices 0,1,2,3 repeating -> first 5 pops produce no shade; first emitted X=0 carries index 1 (6th pixel); total 165 pops.
- Priority: BGP=0xE4, OBP1=0x1B, sprite idx 1, palette 1:
  - priority 0 over bg idx 3 -> shade 2;
  - priority 1 over bg idx 3 -> shade 3;
  - priority 1 over bg idx 0 -> shade 2;
  - sprite idx 0 -> background shade.
- Stall: drop bg_valid_in for 4 T-cycles at X=37 -> rd_en_out=0, no shade emitted, X resumes at 38; still exactly 160 shades.
- Restart and reset: line_start at X=80 -> X restarts at 0 with no stale shade. Async rst_in mid-DRAW -> all outputs 0 immediately, state IDLE.
- bg_ena_in=0, BGP=0x1B, no sprite -> every shade is 3.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU types: mixer FSM states, colour index / shade types and the DMG palette lookup.
package ppu_pkg;

  typedef enum logic [1:0] {IDLE, DISCARD, DRAW, DONE} mixer_state_t;

  typedef logic [1:0] shade_t;
  typedef logic [1:0] color_idx_t;

  // A DMG palette packs four 2-bit shades, index 0 in the low bits.
  function automatic shade_t palette_map(input logic [7:0] palette, input color_idx_t idx);
    return palette[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/pixel_priority_resolver.sv
// Combinational background/sprite arbitration followed by palette lookup.
module pixel_priority_resolver
  import ppu_pkg::*;
(
  input  logic       bg_ena,
  input  color_idx_t bg_pixel,
  input  logic       sprite_valid,
  input  color_idx_t sprite_pixel,
  input  logic       sprite_palette,
  input  logic       sprite_priority,
  input  logic [7:0] bgp,
  input  logic [7:0] obp0,
  input  logic [7:0] obp1,
  output shade_t     shade
);

  color_idx_t bg_idx;
  color_idx_t spr_idx;
  logic       spr_win;

  always_comb begin
    bg_idx  = bg_ena ? bg_pixel : 2'd0;
    spr_idx = sprite_valid ? sprite_pixel : 2'd0;
    // Index 0 is transparent for sprites; a behind-bg sprite only shows through bg colour 0.
    spr_win = (spr_idx != 2'd0) && (!sprite_priority || bg_idx == 2'd0);
    if (spr_win) shade = palette_map(sprite_palette ? obp1 : obp0, spr_idx);
    else         shade = palette_map(bgp, bg_idx);
  end

endmodule

// File: rtl/pixel_mixer.sv
// PPU pixel mixer: pops bg/sprite FIFOs, drops SCX fine-scroll pixels, streams shades per line.
// Optional PIXEL_MIXER_SPRITE_MASK_EN adds sprite_mask_in to hide sprites for layer debugging.
module pixel_mixer
  import ppu_pkg::*;
#(
  parameter  int X_MAX = 160,
  localparam int XW    = $clog2(X_MAX)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          tclk_in,
  input  logic          line_start_in,
  input  logic [7:0]    SCX_in,
  input  logic          bg_ena_in,
  input  logic [7:0]    BGP_in,
  input  logic [7:0]    OBP0_in,
  input  logic [7:0]    OBP1_in,
  input  logic [1:0]    bg_pixel_in,
  input  logic          bg_valid_in,
  input  logic [1:0]    sprite_pixel_in,
  input  logic          sprite_valid_in,
  input  logic          sprite_palette_in,
  input  logic          sprite_priority_in,
`ifdef PIXEL_MIXER_SPRITE_MASK_EN
  input  logic          sprite_mask_in,
`endif
  output logic          rd_en_out,
  output logic [XW-1:0] X_out,
  output shade_t        shade_out,
  output logic          shade_valid_out,
  output logic          line_done_out
);

  localparam int STAGES = 1;

  mixer_state_t  state, state_nxt;
  logic [XW-1:0] x_cnt;
  logic [2:0]    disc_cnt;
  logic          pop;
  logic          last_px;
  logic          spr_vld;
  shade_t        shade_res;
  logic [STAGES:0] vld_pipe;
  logic          unused_scx;

  assign unused_scx = ^SCX_in[7:3];

`ifdef PIXEL_MIXER_SPRITE_MASK_EN
  assign spr_vld = sprite_valid_in && !sprite_mask_in;
`else
  assign spr_vld = sprite_valid_in;
`endif

  assign pop       = tclk_in && bg_valid_in && (state == DISCARD || state == DRAW);
  assign rd_en_out = pop;
  assign last_px   = (x_cnt == XW'(X_MAX - 1));

  pixel_priority_resolver u_resolver (
    .bg_ena          (bg_ena_in),
    .bg_pixel        (bg_pixel_in),
    .sprite_valid    (spr_vld),
    .sprite_pixel    (sprite_pixel_in),
    .sprite_palette  (sprite_palette_in),
    .sprite_priority (sprite_priority_in),
    .bgp             (BGP_in),
    .obp0            (OBP0_in),
    .obp1            (OBP1_in),
    .shade           (shade_res)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (line_start_in) begin
      state_nxt = (SCX_in[2:0] != 3'd0) ? DISCARD : DRAW;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        DISCARD: if (pop && disc_cnt == 3'd1) state_nxt = DRAW;
        DRAW:    if (pop && last_px) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A line_start in the same cycle as a pop kills that pixel so nothing stale leaks out.
  assign vld_pipe[0]  = pop && (state == DRAW) && !line_start_in;
  assign shade_valid_out = vld_pipe[STAGES];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_pipe[STAGES:1] <= '0;
      x_cnt              <= '0;
      disc_cnt           <= 3'd0;
      X_out              <= '0;
      shade_out          <= 2'd0;
      line_done_out      <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      line_done_out      <= (state == DONE) && !line_start_in;
      if (line_start_in) begin
        x_cnt    <= '0;
        disc_cnt <= SCX_in[2:0];
      end else if (pop) begin
        if (state == DISCARD) begin
          disc_cnt <= disc_cnt - 3'd1;
        end else begin
          shade_out <= shade_res;
          X_out     <= x_cnt;
          x_cnt     <= last_px ? '0 : x_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_mixer.sv
// Randomized bench for pixel_mixer against a per-line behavioural model of pops and shades.
module tb_pixel_mixer;
  localparam int X_MAX = 160;
  localparam int XW    = $clog2(X_MAX);

  logic clk_in = 1'b0;
  logic rst_in, tclk_in, line_start_in, bg_ena_in, bg_valid_in;
  logic sprite_valid_in, sprite_palette_in, sprite_priority_in;
  logic [7:0] SCX_in, BGP_in, OBP0_in, OBP1_in;
  logic [1:0] bg_pixel_in, sprite_pixel_in;
  logic rd_en_out, shade_valid_out, line_done_out;
  logic [XW-1:0] X_out;
  logic [1:0] shade_out;

  int total = 0, bad = 0, cyc = 0;
  int exp_x[$], exp_s[$], got_x[$], got_s[$], got_cyc[$];
  int done_n = 0, done_cyc = 0, both_n = 0;

  pixel_mixer #(.X_MAX(X_MAX)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tclk_in(tclk_in), .line_start_in(line_start_in),
    .SCX_in(SCX_in), .bg_ena_in(bg_ena_in), .BGP_in(BGP_in), .OBP0_in(OBP0_in), .OBP1_in(OBP1_in),
    .bg_pixel_in(bg_pixel_in), .bg_valid_in(bg_valid_in), .sprite_pixel_in(sprite_pixel_in),
    .sprite_valid_in(sprite_valid_in), .sprite_palette_in(sprite_palette_in),
    .sprite_priority_in(sprite_priority_in), .rd_en_out(rd_en_out), .X_out(X_out),
    .shade_out(shade_out), .shade_valid_out(shade_valid_out), .line_done_out(line_done_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (shade_valid_out) begin
      got_x.push_back(int'(X_out)); got_s.push_back(int'(shade_out)); got_cyc.push_back(cyc);
    end
    if (line_done_out) begin done_n++; done_cyc = cyc; end
    if (shade_valid_out && line_done_out) both_n++;
  end

  // Reference: transparent sprite idx 0, behind-bg sprites only over bg colour 0.
  function automatic int ref_shade(int bgp, int obp0, int obp1, int ena, int bg,
                                   int sv, int sp, int pal, int pri);
    int b, s, p, idx;
    b = (ena != 0) ? bg : 0;
    s = (sv != 0) ? sp : 0;
    if (s != 0 && (pri == 0 || b == 0)) begin p = (pal != 0) ? obp1 : obp0; idx = s; end
    else begin p = bgp; idx = b; end
    return (p >> (2 * idx)) & 3;
  endfunction

  function automatic int queue_mm();
    int mm = 0;
    if (got_x.size() != exp_x.size()) mm++;
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++)
      if (got_x[i] != exp_x[i] || got_s[i] != exp_s[i]) mm++;
    return mm;
  endfunction

  task automatic clr();
    exp_x.delete(); exp_s.delete(); got_x.delete(); got_s.delete(); got_cyc.delete();
    done_n = 0; both_n = 0; done_cyc = 0;
  endtask

  // mode 0: random all; 1: bg=2, sprite invalid; 2: bg=pop%4; 3: priority cases; 4: random bg, no sprite
  task automatic run_line(input int scx, input int mode, input int stall_at, input int abort_at,
                          input bit restart_pop, output int rd_bad, output int npops);
    int pops, need, stall, budget, ext, x, gap;
    bit bgv, want;
    pops = 0; stall = 0; budget = 0; ext = 0; rd_bad = 0; need = scx % 8 + X_MAX;
    SCX_in = 8'(scx); line_start_in = 1'b1; tclk_in = restart_pop; bg_valid_in = restart_pop;
    @(negedge clk_in); if (rd_en_out !== restart_pop) rd_bad++;
    @(posedge clk_in); #1; line_start_in = 1'b0; tclk_in = 1'b0;
    while ((pops < need || ext < 3) && budget < 3000) begin
      budget++;
      if (pops >= need) ext++;
      x = pops - scx % 8;
      if (stall_at >= 0 && x == stall_at && stall < 4) begin bgv = 1'b0; stall++; end
      else if (mode == 0 || mode == 4) bgv = ($urandom_range(0, 7) != 0);
      else bgv = 1'b1;
      sprite_palette_in = 1'($urandom_range(0, 1)); sprite_priority_in = 1'($urandom_range(0, 1));
      sprite_pixel_in = 2'($urandom_range(0, 3));
      case (mode)
        0: begin bg_pixel_in = 2'($urandom_range(0, 3)); sprite_valid_in = 1'($urandom_range(0, 1)); end
        1: begin bg_pixel_in = 2'd2; sprite_valid_in = 1'b0; end
        2: begin bg_pixel_in = 2'(pops % 4); sprite_valid_in = 1'b0; end
        3: begin
          sprite_valid_in = 1'b1; sprite_palette_in = 1'b1; sprite_pixel_in = 2'd1;
          case (pops % 4)
            0: begin bg_pixel_in = 2'd3; sprite_priority_in = 1'b0; end
            1: begin bg_pixel_in = 2'd3; sprite_priority_in = 1'b1; end
            2: begin bg_pixel_in = 2'd0; sprite_priority_in = 1'b1; end
            default: begin bg_pixel_in = 2'd3; sprite_priority_in = 1'b0; sprite_pixel_in = 2'd0; end
          endcase
        end
        default: begin bg_pixel_in = 2'($urandom_range(0, 3)); sprite_valid_in = 1'b0; end
      endcase
      tclk_in = 1'b1; bg_valid_in = bgv;
      want = bgv && (pops < need);
      @(negedge clk_in); if (rd_en_out !== want) rd_bad++;
      if (want) begin
        if (x >= 0) begin
          exp_x.push_back(x);
          exp_s.push_back(ref_shade(BGP_in, OBP0_in, OBP1_in, bg_ena_in, bg_pixel_in,
                                    sprite_valid_in, sprite_pixel_in, sprite_palette_in, sprite_priority_in));
        end
        pops++;
      end
      @(posedge clk_in); #1; tclk_in = 1'b0;
      if (abort_at >= 0 && pops >= abort_at) begin npops = pops; return; end
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        bg_valid_in = 1'($urandom_range(0, 1));
        @(negedge clk_in); if (rd_en_out !== 1'b0) rd_bad++;
        @(posedge clk_in); #1;
      end
    end
    npops = pops;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; #1 rst_in = 1'b1;
    @(negedge clk_in);
    total++;
    if ({rd_en_out, X_out, shade_out, shade_valid_out, line_done_out} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {rd_en_out, X_out, shade_out, shade_valid_out, line_done_out});
    end
    @(posedge clk_in); #1; rst_in = 1'b0; tclk_in = 1'b1; bg_valid_in = 1'b1;
    @(negedge clk_in);
    total++;
    if (rd_en_out !== 1'b0) begin bad++; $display("FAIL idle_no_pop: rd_en=%b want 0", rd_en_out); end
    @(posedge clk_in); #1; tclk_in = 1'b0;
  endtask

  task automatic test_basic();
    int rb, np, mm;
    clr(); BGP_in = 8'hE4; bg_ena_in = 1'b1;
    run_line(0, 1, -1, -1, 1'b0, rb, np);
    mm = queue_mm();
    total++; if (rb !== 0) begin bad++; $display("FAIL basic_rd_en: %0d bad cycles want 0", rb); end
    total++; if (mm !== 0) begin bad++; $display("FAIL basic_stream: %0d mismatches want 0", mm); end
    total++;
    if (got_s.size() !== 160 || got_s[0] !== 2 || got_x[159] !== 159) begin
      bad++; $display("FAIL basic_shape: n=%0d s0=%0d x159=%0d want 160/2/159", got_s.size(), got_s[0], got_x[159]);
    end
    total++;
    if (done_n !== 1 || done_cyc !== got_cyc[got_cyc.size()-1] + 1) begin
      bad++; $display("FAIL basic_line_done: n=%0d cyc=%0d want 1 at %0d", done_n, done_cyc, got_cyc[got_cyc.size()-1] + 1);
    end
    total++; if (both_n !== 0) begin bad++; $display("FAIL basic_overlap: %0d want 0", both_n); end
  endtask

  task automatic test_scroll();
    int rb, np, mm;
    clr(); BGP_in = 8'hE4; bg_ena_in = 1'b1;
    run_line(5, 2, -1, -1, 1'b0, rb, np);
    mm = queue_mm();
    total++; if (np !== 165 || rb !== 0) begin bad++; $display("FAIL scroll_pops: pops=%0d rd_bad=%0d want 165/0", np, rb); end
    total++;
    if (got_x[0] !== 0 || got_s[0] !== 1) begin bad++; $display("FAIL scroll_first: x=%0d s=%0d want 0/1", got_x[0], got_s[0]); end
    total++; if (mm !== 0) begin bad++; $display("FAIL scroll_stream: %0d mismatches want 0", mm); end
  endtask

  task automatic test_priority();
    int rb, np, mm;
    clr(); BGP_in = 8'hE4; OBP1_in = 8'h1B; OBP0_in = 8'h00; bg_ena_in = 1'b1;
    run_line(0, 3, -1, -1, 1'b0, rb, np);
    mm = queue_mm();
    total++;
    if (got_s[0] !== 2 || got_s[1] !== 3 || got_s[2] !== 2 || got_s[3] !== 3) begin
      bad++; $display("FAIL priority_cases: got %0d %0d %0d %0d want 2 3 2 3", got_s[0], got_s[1], got_s[2], got_s[3]);
    end
    total++; if (mm !== 0 || rb !== 0) begin bad++; $display("FAIL priority_stream: mm=%0d rd_bad=%0d want 0/0", mm, rb); end
  endtask

  task automatic test_stall();
    int rb, np, mm;
    clr(); BGP_in = 8'hE4; bg_ena_in = 1'b1;
    run_line(0, 1, 38, -1, 1'b0, rb, np);
    mm = queue_mm();
    total++; if (rb !== 0) begin bad++; $display("FAIL stall_rd_en: %0d bad cycles want 0", rb); end
    total++;
    if (mm !== 0 || got_x.size() !== 160) begin bad++; $display("FAIL stall_stream: mm=%0d n=%0d want 0/160", mm, got_x.size()); end
  endtask

  task automatic test_bg_disable();
    int rb, np, n3;
    clr(); BGP_in = 8'h1B; bg_ena_in = 1'b0;
    run_line($urandom_range(0, 7), 4, -1, -1, 1'b0, rb, np);
    n3 = 0;
    foreach (got_s[i]) if (got_s[i] != 3) n3++;
    total++;
    if (n3 !== 0 || got_s.size() !== 160) begin bad++; $display("FAIL bg_disable: non3=%0d n=%0d want 0/160", n3, got_s.size()); end
    bg_ena_in = 1'b1;
  endtask

  task automatic test_restart();
    int rb1, rb2, np, mm;
    clr(); BGP_in = 8'($urandom); OBP0_in = 8'($urandom); OBP1_in = 8'($urandom);
    run_line(0, 0, -1, 80, 1'b0, rb1, np);
    run_line(3, 0, -1, -1, 1'b1, rb2, np);
    mm = queue_mm();
    total++; if (rb1 + rb2 !== 0) begin bad++; $display("FAIL restart_rd_en: %0d bad cycles want 0", rb1 + rb2); end
    total++;
    if (mm !== 0 || got_x[80] !== 0 || done_n !== 1) begin
      bad++; $display("FAIL restart_stream: mm=%0d x80=%0d done=%0d want 0/0/1", mm, got_x[80], done_n);
    end
  endtask

  task automatic test_random();
    int rb, np, mm;
    for (int l = 0; l < 3; l++) begin
      clr(); BGP_in = 8'($urandom); OBP0_in = 8'($urandom); OBP1_in = 8'($urandom);
      bg_ena_in = 1'($urandom_range(0, 1));
      run_line($urandom_range(0, 255), 0, -1, -1, 1'b0, rb, np);
      mm = queue_mm();
      total++;
      if (mm !== 0 || rb !== 0 || done_n !== 1 || both_n !== 0) begin
        bad++; $display("FAIL random_line%0d: mm=%0d rd_bad=%0d done=%0d overlap=%0d want 0/0/1/0", l, mm, rb, done_n, both_n);
      end
    end
    bg_ena_in = 1'b1;
  endtask

  task automatic test_async_reset();
    int rb, np, mm;
    clr(); BGP_in = 8'hE4;
    run_line(2, 0, -1, 60, 1'b0, rb, np);
    #2; tclk_in = 1'b1; bg_valid_in = 1'b1; rst_in = 1'b1;
    #1;
    total++;
    if ({rd_en_out, X_out, shade_out, shade_valid_out, line_done_out} !== '0) begin
      bad++; $display("FAIL async_reset: got %b want 0", {rd_en_out, X_out, shade_out, shade_valid_out, line_done_out});
    end
    @(posedge clk_in); #1; rst_in = 1'b0;
    @(negedge clk_in);
    total++; if (rd_en_out !== 1'b0) begin bad++; $display("FAIL post_reset_idle: rd_en=%b want 0", rd_en_out); end
    @(posedge clk_in); #1; tclk_in = 1'b0;
    clr();
    run_line(1, 1, -1, -1, 1'b0, rb, np);
    mm = queue_mm();
    total++; if (mm !== 0 || rb !== 0) begin bad++; $display("FAIL post_reset_line: mm=%0d rd_bad=%0d want 0/0", mm, rb); end
  endtask

  initial begin
    tclk_in = 1'b0; line_start_in = 1'b0; SCX_in = 8'h00; bg_ena_in = 1'b1;
    BGP_in = 8'hE4; OBP0_in = 8'h00; OBP1_in = 8'h00; bg_pixel_in = 2'd0; bg_valid_in = 1'b0;
    sprite_pixel_in = 2'd0; sprite_valid_in = 1'b0; sprite_palette_in = 1'b0; sprite_priority_in = 1'b0;
    test_reset();
    test_basic();
    test_scroll();
    test_priority();
    test_stall();
    test_bg_disable();
    test_restart();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
